// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: FSM states, grant
// encodings, access size codes and the round-robin tie-break helper.
package mem_bus_arbiter_pkg;

   // Transaction FSM: one outstanding bus transaction at most.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no transaction in progress
      ST_ADDR = 2'd1,   // bus_req high, waiting for bus_addr_ok
      ST_WAIT = 2'd2    // address accepted, waiting for bus_data_ok
   } state_e;

   // Which pipeline side owns the current (or last) transaction.
   typedef enum logic {
      GNT_INST = 1'b0,
      GNT_DATA = 1'b1
   } grant_e;

   // Bus access size codes.
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Round-robin pick: a lone requester always wins; on a tie the side that
   // did not win last time is served.
   function automatic grant_e pick_grant(input logic   inst_req,
                                         input logic   data_req,
                                         input grant_e last_grant);
      grant_e g;
      if (inst_req && data_req) begin
         g = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
      end else if (data_req) begin
         g = GNT_DATA;
      end else begin
         g = GNT_INST;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single sram-like memory bus between instruction fetch and
// the MEM-stage load/store path. Round-robin grant, registered bus outputs,
// registered read data with a one-cycle done pulse per side.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   // instruction fetch side
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   output logic [DW-1:0] inst_rdata,
   output logic          inst_done,
   // MEM-stage load/store side
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [AW-1:0] data_addr,
   input  logic [3:0]    data_wstrb,
   input  logic [DW-1:0] data_wdata,
   output logic [DW-1:0] data_rdata,
   output logic          data_done,
   // pipeline stalls
   output logic          stall_if,
   output logic          stall_mem,
   // external bus
   output logic          bus_req,
   output logic          bus_wr,
   output logic [1:0]    bus_size,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_wstrb,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [DW-1:0] bus_rdata
);

   state_e        state_q, state_d;
   grant_e        grant_q, grant_d;
   grant_e        last_grant_q, last_grant_d;

   logic          bus_req_q,   bus_req_d;
   logic          bus_wr_q,    bus_wr_d;
   logic [1:0]    bus_size_q,  bus_size_d;
   logic [AW-1:0] bus_addr_q,  bus_addr_d;
   logic [3:0]    bus_wstrb_q, bus_wstrb_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;

   logic          inst_done_q,  inst_done_d;
   logic          data_done_q,  data_done_d;
   logic [DW-1:0] inst_rdata_q, inst_rdata_d;
   logic [DW-1:0] data_rdata_q, data_rdata_d;

   logic          complete;

   // State and output registers; a reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_INST;
         last_grant_q <= GNT_INST;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_size_q   <= 2'd0;
         bus_addr_q   <= '0;
         bus_wstrb_q  <= 4'b0;
         bus_wdata_q  <= '0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_size_q   <= bus_size_d;
         bus_addr_q   <= bus_addr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_wdata_q  <= bus_wdata_d;
         inst_done_q  <= inst_done_d;
         data_done_q  <= data_done_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Next-state logic: grant in IDLE, walk the address/data handshake, and
   // on completion capture read data and schedule the done pulse.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_size_d   = bus_size_q;
      bus_addr_d   = bus_addr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_wdata_d  = bus_wdata_q;
      inst_done_d  = 1'b0;
      data_done_d  = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      complete     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Requests are still high while their done pulse is visible, so
            // both sides are ignored in that cycle to avoid a repeat access.
            if ((inst_req || data_req) && !(inst_done_q || data_done_q)) begin
               grant_d   = pick_grant(inst_req, data_req, last_grant_q);
               bus_req_d = 1'b1;
               state_d   = ST_ADDR;
               if (grant_d == GNT_INST) begin
                  bus_wr_d    = 1'b0;
                  bus_size_d  = SZ_WORD;
                  bus_addr_d  = inst_addr;
                  bus_wstrb_d = 4'b0;
                  bus_wdata_d = '0;
               end else begin
                  bus_wr_d    = data_wr;
                  bus_size_d  = data_size;
                  bus_addr_d  = data_addr;
                  bus_wstrb_d = data_wr ? data_wstrb : 4'b0;
                  bus_wdata_d = data_wdata;
               end
            end
         end
         ST_ADDR: begin
            // data_ok without addr_ok is a slave protocol error and is ignored.
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               if (bus_data_ok) begin
                  complete = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus_data_ok) begin
               complete = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
         end
      endcase

      if (complete) begin
         state_d      = ST_IDLE;
         last_grant_d = grant_q;
         if (grant_q == GNT_INST) begin
            inst_rdata_d = bus_rdata;
            inst_done_d  = 1'b1;
         end else begin
            data_rdata_d = bus_rdata;
            data_done_d  = 1'b1;
         end
      end
   end

   assign bus_req    = bus_req_q;
   assign bus_wr     = bus_wr_q;
   assign bus_size   = bus_size_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wstrb  = bus_wstrb_q;
   assign bus_wdata  = bus_wdata_q;

   assign inst_done  = inst_done_q;
   assign data_done  = data_done_q;
   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;

   assign stall_if   = inst_req & ~inst_done_q;
   assign stall_mem  = data_req & ~data_done_q;

   // Address-phase fields must not move while the slave has not accepted them.
   property p_addr_hold;
      @(posedge clk) disable iff (!rst)
         (state_q == ST_ADDR && !bus_addr_ok) |=>
            (bus_req_q && $stable(bus_addr_q) && $stable(bus_wr_q) &&
             $stable(bus_size_q) && $stable(bus_wstrb_q) && $stable(bus_wdata_q));
   endproperty
   a_addr_hold: assert property (p_addr_hold);

   // Only one transaction completes at a time, so done pulses never overlap.
   a_done_excl: assert property (@(posedge clk) disable iff (!rst)
                                 !(inst_done_q && data_done_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// reset sequence, and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_req;
   logic [31:0]   inst_addr;
   logic [31:0]   inst_rdata;
   logic          inst_done;
   logic          data_req;
   logic          data_wr;
   logic [1:0]    data_size;
   logic [31:0]   data_addr;
   logic [3:0]    data_wstrb;
   logic [31:0]   data_wdata;
   logic [31:0]   data_rdata;
   logic          data_done;
   logic          stall_if;
   logic          stall_mem;
   logic          bus_req;
   logic          bus_wr;
   logic [1:0]    bus_size;
   logic [31:0]   bus_addr;
   logic [3:0]    bus_wstrb;
   logic [31:0]   bus_wdata;
   logic          bus_addr_ok;
   logic          bus_data_ok;
   logic [31:0]   bus_rdata;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   int          checks = 0;
   int          errors = 0;
   int          ntxn   = 0;
   logic [31:0] exp_irdata;
   logic [31:0] exp_drdata;
   bit          model_last;   // side that completed last: 0 = INST, 1 = DATA

   typedef struct {
      logic        ireq, dreq, wr;
      logic [1:0]  sz;
      logic [31:0] daddr;
      logic [3:0]  strb;
      logic [31:0] wd, iaddr;
      int          aw, dw;
      bit          viol;
      logic [31:0] rd;
      bit          eg;        // expected winner: 0 = INST, 1 = DATA
      logic        ewr;
      logic [1:0]  esz;
      logic [31:0] eaddr;
      logic [3:0]  estrb;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle view: bus_req, done pulses, stall equations and held read data.
   task automatic chk_cycle(input bit ebr, input bit eid, input bit edd);
      chk("bus_req",    32'(bus_req),    32'(ebr));
      chk("inst_done",  32'(inst_done),  32'(eid));
      chk("data_done",  32'(data_done),  32'(edd));
      chk("stall_if",   32'(stall_if),   32'(inst_req & ~eid));
      chk("stall_mem",  32'(stall_mem),  32'(data_req & ~edd));
      chk("inst_rdata", inst_rdata, exp_irdata);
      chk("data_rdata", data_rdata, exp_drdata);
   endtask

   task automatic chk_bus(input logic ewr, input logic [1:0] esz, input logic [31:0] eaddr,
                          input logic [3:0] estrb, input logic [31:0] ewd);
      chk("bus_wr",    32'(bus_wr),    32'(ewr));
      chk("bus_size",  32'(bus_size),  32'(esz));
      chk("bus_addr",  bus_addr,       eaddr);
      chk("bus_wstrb", 32'(bus_wstrb), 32'(estrb));
      if (ewr) chk("bus_wdata", bus_wdata, ewd);
   endtask

   task automatic chk_bus_zero();
      chk("rst_bus_wr",    32'(bus_wr),    32'd0);
      chk("rst_bus_size",  32'(bus_size),  32'd0);
      chk("rst_bus_addr",  bus_addr,       32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      chk("rst_bus_wdata", bus_wdata,      32'd0);
   endtask

   // One transaction. Caller has just set the request inputs (cycle N, DUT
   // idle and no done showing). The bench plays the slave: aw cycles without
   // addr_ok (data_ok forced high in those if viol), then dw cycles of data
   // wait. Returns in the cycle after the done pulse.
   task automatic run_txn(input int aw, input int dw, input bit viol, input logic [31:0] rd,
                          input bit eg, input logic ewr, input logic [1:0] esz,
                          input logic [31:0] eaddr, input logic [3:0] estrb, input logic [31:0] ewd);
      #1;
      chk_cycle(1'b0, 1'b0, 1'b0);
      step();
      chk_cycle(1'b1, 1'b0, 1'b0);
      chk_bus(ewr, esz, eaddr, estrb, ewd);
      for (int i = 0; i < aw; i++) begin
         bus_addr_ok = 1'b0;
         bus_data_ok = viol;
         bus_rdata   = $urandom;
         step();
         chk_cycle(1'b1, 1'b0, 1'b0);
         chk_bus(ewr, esz, eaddr, estrb, ewd);
      end
      bus_addr_ok = 1'b1;
      bus_data_ok = (dw == 0);
      bus_rdata   = (dw == 0) ? rd : $urandom;
      step();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (dw > 0) begin
         chk_cycle(1'b0, 1'b0, 1'b0);
         for (int i = 1; i < dw; i++) begin
            step();
            chk_cycle(1'b0, 1'b0, 1'b0);
         end
         bus_data_ok = 1'b1;
         bus_rdata   = rd;
         step();
         bus_data_ok = 1'b0;
      end
      if (eg) exp_drdata = rd;
      else    exp_irdata = rd;
      chk_cycle(1'b0, !eg, eg);
      model_last = eg;
      ntxn++;
      $display("txn %0d: %s addr=0x%08h wr=%0d aw=%0d dw=%0d viol=%0d rdata=0x%08h",
               ntxn, eg ? "DATA" : "INST", eaddr, ewr, aw, dw, viol, rd);
      step();
      chk_cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply(input vec_t v);
      inst_req   = v.ireq;
      data_req   = v.dreq;
      data_wr    = v.wr;
      data_size  = v.sz;
      data_addr  = v.daddr;
      data_wstrb = v.strb;
      data_wdata = v.wd;
      inst_addr  = v.iaddr;
   endtask

   // Bench-level watchdog: the run is step-counted, so this only trips on a
   // simulator-level stall.
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      //        ireq  dreq  wr    sz    daddr         strb  wd            iaddr         aw dw viol rd            eg ewr   esz   eaddr         estrb
      vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'hF, 32'hCAFE_0000, 32'hBFC0_0000, 0, 0, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'hF, 32'hCAFE_0000, 32'hBFC0_0000, 0, 0, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 4'h0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'hF, 32'hCAFE_0000, 32'hBFC0_0000, 1, 1, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 4'hF, 32'hCAFE_0000, 32'hBFC0_0000, 0, 2, 1'b0, 32'h4444_4444, 1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 4'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         4'h0, 32'h0,         32'hBFC0_0000, 0, 0, 1'b0, 32'h3C08_BFC0, 1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 4'h0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 4'h1, 32'h0000_00AB, 32'hBFC0_0000, 2, 1, 1'b0, 32'h0BAD_0005, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 4'h1};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h8000_0102, 4'hC, 32'hBEEF_0000, 32'hBFC0_0000, 1, 0, 1'b0, 32'h0BAD_0006, 1'b1, 1'b1, 2'd1, 32'h8000_0102, 4'hC};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         4'h0, 32'h0,         32'hBFC0_0010, 3, 0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, 2'd2, 32'hBFC0_0010, 4'h0};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h8000_0001, 4'h2, 32'h0,         32'hBFC0_0014, 0, 1, 1'b0, 32'h5566_7788, 1'b1, 1'b0, 2'd0, 32'h8000_0001, 4'h0};
      vecs[9] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h8000_0001, 4'h2, 32'h0,         32'hBFC0_0014, 2, 2, 1'b1, 32'h7777_7777, 1'b0, 1'b0, 2'd2, 32'hBFC0_0014, 4'h0};

      // Reset with both requests already high.
      rst         = 1'b0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'h0;
      apply(vecs[0]);
      exp_irdata  = 32'h0;
      exp_drdata  = 32'h0;
      model_last  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      chk_cycle(1'b0, 1'b0, 1'b0);
      chk_bus_zero();
      rst = 1'b1;

      // Directed vectors: tie alternation from reset, zero-wait fetch,
      // byte store with waits, protocol-violation noise, load strobe masking.
      for (int r = 0; r < 10; r++) begin
         apply(vecs[r]);
         run_txn(vecs[r].aw, vecs[r].dw, vecs[r].viol, vecs[r].rd, vecs[r].eg,
                 vecs[r].ewr, vecs[r].esz, vecs[r].eaddr, vecs[r].estrb, vecs[r].wd);
      end
      inst_req = 1'b0;
      data_req = 1'b0;

      // Randomized traffic: requesters keep a pending request until served.
      begin
         bit ip = 1'b0;
         bit dp = 1'b0;
         bit eg;
         for (int t = 0; t < 150; t++) begin
            if (!ip && ($urandom_range(1) == 1)) begin
               ip = 1'b1;
               inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && ($urandom_range(1) == 1)) begin
               dp = 1'b1;
               data_wr    = 1'($urandom_range(1));
               data_size  = 2'($urandom_range(2));
               data_addr  = $urandom;
               data_wstrb = 4'($urandom_range(15));
               data_wdata = $urandom;
            end
            if (!ip && !dp) begin
               ip = 1'b1;
               inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            inst_req = ip;
            data_req = dp;
            eg = (ip && dp) ? !model_last : dp;
            if (eg)
               run_txn($urandom_range(2), $urandom_range(2), 1'($urandom_range(1)), $urandom, eg,
                       data_wr, data_size, data_addr, data_wr ? data_wstrb : 4'h0, data_wdata);
            else
               run_txn($urandom_range(2), $urandom_range(2), 1'($urandom_range(1)), $urandom, eg,
                       1'b0, SZ_WORD, inst_addr, 4'h0, 32'h0);
            if (eg) dp = 1'b0;
            else    ip = 1'b0;
            inst_req = ip;
            data_req = dp;
         end
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      step();

      // Leave last_grant at DATA, then abandon a load in WAIT with a reset.
      data_req = 1'b1; data_wr = 1'b0; data_size = SZ_WORD;
      data_addr = 32'h9000_0010; data_wstrb = 4'hF; data_wdata = 32'hCAFE_0001;
      run_txn(0, 0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, SZ_WORD, 32'h9000_0010, 4'h0, 32'h0);
      data_addr = 32'h9000_0020;
      #1;
      step();
      chk_cycle(1'b1, 1'b0, 1'b0);
      bus_addr_ok = 1'b1;
      step();
      bus_addr_ok = 1'b0;
      chk_cycle(1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      exp_irdata = 32'h0;
      exp_drdata = 32'h0;
      model_last = 1'b0;
      chk_cycle(1'b0, 1'b0, 1'b0);
      chk_bus_zero();
      data_req = 1'b0;
      step();
      rst = 1'b1;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'hDEAD_BEEF;
      step();
      bus_data_ok = 1'b0;
      chk_cycle(1'b0, 1'b0, 1'b0);
      step();
      chk_cycle(1'b0, 1'b0, 1'b0);

      // Fresh tie after reset: last_grant is INST again, so DATA wins.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
      data_req = 1'b1; data_wr = 1'b1; data_size = SZ_HALF;
      data_addr = 32'h8000_0200; data_wstrb = 4'h3; data_wdata = 32'h0000_1234;
      run_txn(1, 0, 1'b0, 32'h0BAD_0007, 1'b1, 1'b1, SZ_HALF, 32'h8000_0200, 4'h3, 32'h0000_1234);
      data_req = 1'b0;
      run_txn(0, 1, 1'b0, 32'h2402_0001, 1'b0, 1'b0, SZ_WORD, 32'hBFC0_0100, 4'h0, 32'h0);
      inst_req = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
